// File: rtl/rv_handshake_monitor.sv
// ---------------------------------------------------------------------------
// rv_handshake_monitor
//
// Passive ready/valid protocol monitor for NUM_CH independent channels.
// For every channel it checks that:
//   * valid stays asserted until the beat is accepted,
//   * the payload stays stable while the beat is stalled,
//   * a stall never lasts TIMEOUT cycles or more (TIMEOUT = 0 disables this).
// It also counts completed transfers. Violations are kept as sticky
// registered flags, so regressions and formal runs can read and clear them.
//
// Ports:
//   CLK             clock; all state changes on the rising edge
//   RESETN          synchronous active-low reset; outranks clear
//   clear           synchronous clear of transfer counters and error flags
//                   (FSM, captured payload and stall counter keep running)
//   ch_valid        per-channel valid, bit i = channel i
//   ch_ready        per-channel ready
//   ch_data         payloads, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   err_valid_drop  sticky: valid deasserted while stalled
//   err_data_change sticky: payload changed while stalled
//   err_timeout     sticky: stall reached TIMEOUT cycles
//   any_error       OR of all error flags
//   xfer_count      saturating transfer counts, channel i at
//                   [i*CNT_WIDTH +: CNT_WIDTH]
// ---------------------------------------------------------------------------
module rv_handshake_monitor #(
    parameter int NUM_CH     = 3,
    parameter int DATA_WIDTH = 5,
    parameter int TIMEOUT    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           CLK,
    input  logic                           RESETN,
    input  logic                           clear,
    input  logic [NUM_CH-1:0]              ch_valid,
    input  logic [NUM_CH-1:0]              ch_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data,
    output logic [NUM_CH-1:0]              err_valid_drop,
    output logic [NUM_CH-1:0]              err_data_change,
    output logic [NUM_CH-1:0]              err_timeout,
    output logic                           any_error,
    output logic [NUM_CH*CNT_WIDTH-1:0]    xfer_count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] TO_VAL  = CNT_WIDTH'(TIMEOUT);
    // A limit the stall counter can never hold would otherwise alias after
    // truncation, so such a limit simply disables the check.
    localparam bit TO_ENABLE = (TIMEOUT != 0) && ($clog2(TIMEOUT + 1) <= CNT_WIDTH);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic                  v;
            logic                  r;
            logic [DATA_WIDTH-1:0] d;

            state_t                state_reg;
            logic [DATA_WIDTH-1:0] cap_reg;
            logic [CNT_WIDTH-1:0]  stall_reg;
            logic [CNT_WIDTH-1:0]  cnt_reg;
            logic                  drop_reg;
            logic                  chg_reg;
            logic                  to_reg;

            logic                  stalling;
            logic [CNT_WIDTH-1:0]  stall_next;
            logic                  xfer_ev;
            logic                  drop_ev;
            logic                  chg_ev;
            logic                  to_ev;

            assign v = ch_valid[gi];
            assign r = ch_ready[gi];
            assign d = ch_data[gi*DATA_WIDTH +: DATA_WIDTH];

            // Events seen on this edge. stall_next is the stall length after
            // the edge for a cycle that stalls; the timeout compares against
            // it so the flag rises on the very edge the limit is reached.
            always_comb begin
                stalling   = v && !r;
                stall_next = stall_reg;
                xfer_ev    = v && r;
                drop_ev    = 1'b0;
                chg_ev     = 1'b0;
                if (state_reg == ST_IDLE) begin
                    stall_next = CNT_WIDTH'(1);
                end else begin
                    stall_next = (stall_reg == CNT_MAX) ? stall_reg : stall_reg + 1'b1;
                    drop_ev    = !v;
                    chg_ev     = v && (d != cap_reg);
                end
                to_ev = TO_ENABLE && stalling && (stall_next == TO_VAL);
            end

            always_ff @(posedge CLK) begin
                if (!RESETN) begin
                    state_reg <= ST_IDLE;
                    cap_reg   <= '0;
                    stall_reg <= '0;
                    cnt_reg   <= '0;
                    drop_reg  <= 1'b0;
                    chg_reg   <= 1'b0;
                    to_reg    <= 1'b0;
                end else begin
                    // Stall tracking runs regardless of clear.
                    case (state_reg)
                        ST_IDLE: begin
                            if (stalling) begin
                                state_reg <= ST_WAIT;
                                cap_reg   <= d;
                                stall_reg <= stall_next;
                            end
                        end
                        ST_WAIT: begin
                            if (!v) begin
                                state_reg <= ST_IDLE;
                                stall_reg <= '0;
                            end else begin
                                if (chg_ev) begin
                                    cap_reg <= d;
                                end
                                if (r) begin
                                    state_reg <= ST_IDLE;
                                    stall_reg <= '0;
                                end else begin
                                    stall_reg <= stall_next;
                                end
                            end
                        end
                        default: state_reg <= ST_IDLE;
                    endcase

                    if (clear) begin
                        cnt_reg  <= '0;
                        drop_reg <= 1'b0;
                        chg_reg  <= 1'b0;
                        to_reg   <= 1'b0;
                    end else begin
                        if (xfer_ev && (cnt_reg != CNT_MAX)) begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                        if (drop_ev) drop_reg <= 1'b1;
                        if (chg_ev)  chg_reg  <= 1'b1;
                        if (to_ev)   to_reg   <= 1'b1;
                    end
                end
            end

            assign err_valid_drop[gi]                    = drop_reg;
            assign err_data_change[gi]                   = chg_reg;
            assign err_timeout[gi]                       = to_reg;
            assign xfer_count[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
        end
    endgenerate

    assign any_error = |{err_valid_drop, err_data_change, err_timeout};

endmodule
